// File: rtl/reduce_exec.sv
// reduce_exec: length-prefixed stream reduction engine between two show-ahead FIFOs
module reduce_exec #(
    parameter int DWIDTH        = 8,
    parameter int CNT_WIDTH     = 8,
    parameter int PKT_CNT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ififo_rdy,
    input  logic [DWIDTH-1:0]        idata,
    output logic                     ififo_pop,
    input  logic [1:0]               mode,
    input  logic                     ofifo_not_full,
    output logic                     ofifo_push,
    output logic [DWIDTH-1:0]        odata,
    output logic                     exec_idle,
    output logic [PKT_CNT_WIDTH-1:0] pkt_count
);
    typedef enum logic [1:0] {IDLE, ACCUM, PUSH} state_t;
    state_t                   state_q, state_d;
    logic [CNT_WIDTH-1:0]     cnt_q, cnt_d;
    logic [1:0]               op_q, op_d;
    logic [DWIDTH-1:0]        acc_q, acc_d, fold;
    logic [PKT_CNT_WIDTH-1:0] pkt_q, pkt_d;
    logic                     hdr_pop, hdr_zero, last_pop;

    // state and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= 2'd0;
            acc_q   <= '0;
            pkt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            acc_q   <= acc_d;
            pkt_q   <= pkt_d;
        end
    end

    // FIFO handshakes; a header is any word popped outside ACCUM
    always_comb begin
        ififo_pop  = ififo_rdy && (state_q != PUSH || ofifo_not_full);
        ofifo_push = state_q == PUSH && ofifo_not_full;
        hdr_pop    = ififo_pop && state_q != ACCUM;
        hdr_zero   = idata[CNT_WIDTH-1:0] == '0;
        last_pop   = state_q == ACCUM && ififo_pop && cnt_q == CNT_WIDTH'(1);
        exec_idle  = state_q == IDLE;
        odata      = acc_q;
        pkt_count  = pkt_q;
    end

    // next state: a header pop wins, including the one overlapping a push
    always_comb begin
        state_d = hdr_pop ? (hdr_zero ? PUSH : ACCUM) :
                  last_pop ? PUSH :
                  ofifo_push ? IDLE :
                  state_q == PUSH || state_q == ACCUM ? state_q : IDLE;
    end

    // selected operator folded into the accumulator; ADD drops its carry
    always_comb begin
        fold = op_q == 2'd0 ? acc_q ^ idata :
               op_q == 2'd1 ? acc_q + idata :
               op_q == 2'd2 ? acc_q & idata : acc_q | idata;
    end

    // datapath next values: header loads identity, data words fold and count down
    always_comb begin
        cnt_d = cnt_q;
        op_d  = op_q;
        acc_d = acc_q;
        pkt_d = ofifo_push ? pkt_q + PKT_CNT_WIDTH'(1) : pkt_q;
        if (hdr_pop) begin
            cnt_d = idata[CNT_WIDTH-1:0];
            op_d  = mode;
            acc_d = mode == 2'd2 ? '1 : '0;
        end else if (state_q == ACCUM && ififo_pop) begin
            cnt_d = cnt_q - CNT_WIDTH'(1);
            acc_d = fold;
        end
    end
endmodule

// File: tb/tb_reduce_exec.sv
// tb_reduce_exec: directed table vectors plus hand sequences for stalls, reset and wrap
module tb_reduce_exec;
    logic       clk, rst, ififo_rdy, ififo_pop, ofifo_not_full, ofifo_push, exec_idle;
    logic [7:0] idata, odata;
    logic [1:0] mode;
    logic [3:0] pkt_count;

    reduce_exec #(.DWIDTH(8), .CNT_WIDTH(8), .PKT_CNT_WIDTH(4)) dut (
        .clk(clk), .rst(rst), .ififo_rdy(ififo_rdy), .idata(idata), .ififo_pop(ififo_pop),
        .mode(mode), .ofifo_not_full(ofifo_not_full), .ofifo_push(ofifo_push),
        .odata(odata), .exec_idle(exec_idle), .pkt_count(pkt_count)
    );

    typedef struct {
        logic [1:0] m;
        int         len;
        logic [7:0] d [4];
        logic [7:0] exp;
    } vec_t;

    vec_t       tbl [10];
    logic [9:0] in_q [$];
    logic [7:0] out_q [$];
    logic       rdy_en, rnd;
    int         npass, ntot, cycle, first_pop, last_push, tp;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic set_vec(input int i, input logic [1:0] m, input int len, input logic [7:0] d0,
                           input logic [7:0] d1, input logic [7:0] d2, input logic [7:0] d3,
                           input logic [7:0] exp);
        tbl[i].m = m;
        tbl[i].len = len;
        tbl[i].d[0] = d0;
        tbl[i].d[1] = d1;
        tbl[i].d[2] = d2;
        tbl[i].d[3] = d3;
        tbl[i].exp = exp;
    endtask

    // data words carry the inverted mode so a mid-packet mode change is always exercised
    task automatic load(input int i);
        in_q.push_back({tbl[i].m, 8'(tbl[i].len)});
        for (int k = 0; k < tbl[i].len; k++) in_q.push_back({~tbl[i].m, tbl[i].d[k]});
    endtask

    task automatic cyc();
        if (rnd) begin
            rdy_en = 1'($urandom_range(0, 1));
            ofifo_not_full = $urandom_range(0, 2) != 0;
        end
        ififo_rdy = rdy_en && in_q.size() > 0;
        idata = in_q.size() > 0 ? in_q[0][7:0] : 8'h00;
        mode = in_q.size() > 0 ? in_q[0][9:8] : 2'd0;
        #1;
        if (ififo_pop) begin
            chk("pop_without_rdy", 32'(ififo_rdy), 32'd1);
            if (in_q.size() > 0) in_q.pop_front();
            if (first_pop < 0) first_pop = cycle;
        end
        if (ofifo_push) begin
            chk("push_while_full", 32'(ofifo_not_full), 32'd1);
            out_q.push_back(odata);
            last_push = cycle;
        end
        @(posedge clk);
        #1;
        cycle++;
    endtask

    task automatic run_until(input int n, input int budget, input string nm);
        int k;
        k = 0;
        while (out_q.size() < n && k < budget) begin
            cyc();
            k++;
        end
        chk(nm, 32'(out_q.size()), 32'(n));
    endtask

    task automatic check_results(input string nm);
        for (int i = 0; i < 10; i++)
            if (i < out_q.size()) chk($sformatf("%s_pkt%0d", nm, i), 32'(out_q[i]), 32'(tbl[i].exp));
    endtask

    initial begin
        npass = 0; ntot = 0; cycle = 0; first_pop = -1; last_push = -1;
        rst = 1'b1; rdy_en = 1'b0; rnd = 1'b0; ofifo_not_full = 1'b1;
        ififo_rdy = 1'b0; idata = 8'h00; mode = 2'd0;
        set_vec(0, 2'd0, 4, 8'h16, 8'h05, 8'h08, 8'hFF, 8'hE4);
        set_vec(1, 2'd0, 3, 8'h44, 8'h76, 8'h65, 8'h00, 8'h57);
        set_vec(2, 2'd1, 3, 8'h80, 8'h80, 8'h01, 8'h00, 8'h01);
        set_vec(3, 2'd2, 2, 8'hF0, 8'h3C, 8'h00, 8'h00, 8'h30);
        set_vec(4, 2'd2, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF);
        set_vec(5, 2'd3, 2, 8'h0A, 8'h05, 8'h00, 8'h00, 8'h0F);
        set_vec(6, 2'd0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        set_vec(7, 2'd1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        set_vec(8, 2'd3, 1, 8'hA5, 8'h00, 8'h00, 8'h00, 8'hA5);
        set_vec(9, 2'd1, 4, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFC);
        @(posedge clk);
        #1;
        cyc();
        cyc();
        rst = 1'b0;
        chk("rst_idle", 32'(exec_idle), 32'd1);
        chk("rst_odata", 32'(odata), 32'd0);
        chk("rst_pkt", 32'(pkt_count), 32'd0);
        chk("rst_push", 32'(ofifo_push), 32'd0);
        chk("rst_pop", 32'(ififo_pop), 32'd0);

        // continuous stream: results, N+1 throughput, header popped in push cycle
        rdy_en = 1'b1;
        cycle = 0; first_pop = -1;
        for (int i = 0; i < 10; i++) load(i);
        run_until(10, 200, "stream_done");
        check_results("stream");
        tp = 0;
        for (int i = 0; i < 10; i++) tp += tbl[i].len + 1;
        chk("throughput", 32'(last_push - first_pop), 32'(tp));
        chk("stream_pkt", 32'(pkt_count), 32'd10);
        chk("stream_idle", 32'(exec_idle), 32'd1);

        // random input gaps and output backpressure
        out_q.delete();
        rnd = 1'b1;
        for (int i = 0; i < 10; i++) load(i);
        run_until(10, 2000, "random_done");
        check_results("random");
        chk("random_pkt", 32'(pkt_count), 32'd4);

        // five-cycle full stall at PUSH with the next header waiting
        rnd = 1'b0; rdy_en = 1'b1; ofifo_not_full = 1'b0;
        out_q.delete();
        load(5);
        load(6);
        repeat (3) cyc();
        for (int i = 0; i < 5; i++) begin
            chk("stall_push", 32'(ofifo_push), 32'd0);
            chk("stall_pop", 32'(ififo_pop), 32'd0);
            chk("stall_odata", 32'(odata), 32'h0F);
            cyc();
        end
        ofifo_not_full = 1'b1;
        cyc();
        cyc();
        chk("stall_count", 32'(out_q.size()), 32'd2);
        if (out_q.size() == 2) begin
            chk("stall_or", 32'(out_q[0]), 32'h0F);
            chk("stall_zero", 32'(out_q[1]), 32'h00);
        end
        chk("stall_pkt", 32'(pkt_count), 32'd6);

        // reset after two of four data pops
        out_q.delete();
        set_vec(4, 2'd0, 4, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04);
        load(4);
        repeat (3) cyc();
        rdy_en = 1'b0;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("mid_rst_idle", 32'(exec_idle), 32'd1);
        chk("mid_rst_odata", 32'(odata), 32'd0);
        chk("mid_rst_pkt", 32'(pkt_count), 32'd0);
        chk("mid_rst_push", 32'(ofifo_push), 32'd0);
        chk("mid_rst_left", 32'(in_q.size()), 32'd2);
        cyc();
        chk("mid_rst_nopush", 32'(out_q.size()), 32'd0);
        in_q.delete();
        rdy_en = 1'b1;
        load(2);
        run_until(1, 50, "post_rst_done");
        if (out_q.size() > 0) chk("post_rst_add", 32'(out_q[0]), 32'h01);
        chk("post_rst_pkt", 32'(pkt_count), 32'd1);

        // sixteen zero-length AND packets wrap the 4-bit packet counter
        out_q.delete();
        set_vec(4, 2'd2, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF);
        for (int i = 0; i < 16; i++) load(4);
        run_until(16, 100, "wrap_done");
        tp = 0;
        for (int i = 0; i < out_q.size(); i++) if (out_q[i] !== 8'hFF) tp++;
        chk("wrap_identity_errs", 32'(tp), 32'd0);
        chk("wrap_pkt", 32'(pkt_count), 32'd1);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule

// File: doc/reduce_exec.md
# reduce_exec

Length-prefixed stream reduction engine, the parametrised successor to the byte-XOR executor. It pops a header word holding the element count from an input FIFO, then folds that many data words with a per-packet selectable operator (XOR, ADD, AND or OR). It pushes one result word per packet to an output FIFO. It sits between two show-ahead (first-word-fall-through) FIFOs and keeps a running count of completed packets.

## Interface
Parameters:
- DWIDTH, 8, data word width (≥ 2)
- CNT_WIDTH, 8, header count field width; must be ≤ DWIDTH; count = idata[CNT_WIDTH-1:0]
- PKT_CNT_WIDTH, 16, width of completed-packet counter

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- ififo_rdy  in  1  input FIFO non-empty; idata valid whenever high
- idata  in  DWIDTH  input FIFO head word
- ififo_pop  out  1  combinational; consumes idata this cycle; never high while ififo_rdy low
- mode  in  2  operator select, sampled only on header pop: 0 XOR, 1 ADD, 2 AND, 3 OR
- ofifo_not_full  in  1  output FIFO can accept a word this cycle
- ofifo_push  out  1  combinational; writes odata this cycle
- odata  out  DWIDTH  registered accumulator value
- exec_idle  out  1  high in IDLE state
- pkt_count  out  PKT_CNT_WIDTH  completed (pushed) packets, wraps to 0

## Operation
- States: IDLE, ACCUM, PUSH. Registers: state, cnt (CNT_WIDTH), op (2), acc (DWIDTH), pkt_count.
- IDLE: if ififo_rdy, pop the header and latch cnt = idata[CNT_WIDTH-1:0] and op = mode.
  - Load acc with the operator identity: 0 for XOR, ADD and OR; all-ones for AND.
  - If the header count is 0, go to PUSH; otherwise go to ACCUM.
  - If ififo_rdy is low, stay in IDLE.
- ACCUM: if ififo_rdy, pop, set acc = acc OP idata, and decrement cnt.
  - If cnt was 1, go to PUSH.
  - If ififo_rdy is low, hold all registers (gaps in the input stream are allowed).
- ADD is modulo 2^DWIDTH; the carry is discarded.
- PUSH: ofifo_push = ofifo_not_full; odata = acc.
  - On push, increment pkt_count.
  - Also on push: if ififo_rdy, pop the next header in the same cycle (IDLE header actions apply) and go to ACCUM, or back to PUSH if its count is 0. Otherwise go to IDLE.
  - If ofifo_not_full is low, stay in PUSH with acc held and no pop.
- Zero-length packet: pushes the operator identity (for example 0xFF for AND at DWIDTH=8).
- Header bits above CNT_WIDTH are ignored.
- mode changes mid-packet have no effect; op is held until the next header.

## Timing
- Reset values: state IDLE, acc 0, cnt 0, op 0, pkt_count 0. Outputs after reset: ofifo_push 0, ififo_pop 0 (while in IDLE with ififo_rdy low), odata 0, exec_idle 1.
- Reset mid-packet discards the partial packet: no push, and the remaining data words stay in the input FIFO.
- Pop and push are combinational from state and the FIFO flags; all other outputs are registered.
- Latency: the push is asserted the cycle after the last data pop, when not full.
- Steady-state throughput with continuous input and an unblocked output: N+1 cycles per packet of N data words.
- Simultaneous push and header pop in PUSH is legal and required.
- pkt_count wraps from 2^PKT_CNT_WIDTH-1 to 0.

## Test plan
- XOR, back-to-back: stream 0x04,0x16,0x05,0x08,0xFF, 0x03,0x44,0x76,0x65 with mode=0 -> pushes 0xE4 then 0x57. The second header is popped in the push cycle. pkt_count=2.
- ADD wrap: mode=1, stream 0x03,0x80,0x80,0x01 -> push 0x01.
- AND and zero length: mode=2, stream 0x02,0xF0,0x3C -> push 0x30; then header 0x00 -> push 0xFF, with no data pop.
- Backpressure and gaps: ififo_rdy toggles randomly and ofifo_not_full is held low 5 cycles at PUSH.
  - Results match the model.
  - No pop occurs while ififo_rdy is low; no push occurs while full.
  - odata stays stable during the stall.
- mode change mid-packet: mode=3 at header, then switched to 0 during data; stream 0x02,0x0A,0x05 -> push 0x0F (OR).
- Reset mid-packet: assert rst after 2 of 4 data pops.
  - Next cycle: exec_idle=1, odata=0, pkt_count=0, and no push.
  - A subsequent clean packet reduces correctly.
